dht11_emulator: RTL and testbench



---
 rtl/dht11_emulator.sv | 191 +++++++++++++++++++
 tb/tb_dht11_emulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dht11_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dht11_emulator : DHT11 single-wire responder (start detect, preamble,      |
// |                  40-bit frame). Optional DHT11_EMU_FAULT_EN adds fault_chk. |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module dht11_emulator #(
    parameter int unsigned CLK_FREQ_MHZ  = 50,
    parameter int unsigned START_MIN_US  = 18000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned HOLDOFF_US    = 1000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    inout  wire        io_dht11,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
`ifdef DHT11_EMU_FAULT_EN
    input  logic       fault_chk,
`endif
    output logic       busy,
    output logic       frame_done
);

    function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned c_START_CYC = START_MIN_US  * CLK_FREQ_MHZ;
    localparam int unsigned c_GAP_CYC   = RESP_DELAY_US * CLK_FREQ_MHZ;
    localparam int unsigned c_HOLD_CYC  = HOLDOFF_US    * CLK_FREQ_MHZ;
    localparam int unsigned c_MAX_CYC   = f_max(f_max(c_START_CYC, c_HOLD_CYC),
                                                f_max(80 * CLK_FREQ_MHZ, c_GAP_CYC));
    localparam int unsigned CW          = $clog2(c_MAX_CYC + 1);

    // Terminal counts: a state lasting N cycles exits when the counter reads N-1.
    localparam logic [CW-1:0] c_TC_START = CW'(c_START_CYC);
    localparam logic [CW-1:0] c_TC_GAP   = CW'(c_GAP_CYC - 1);
    localparam logic [CW-1:0] c_TC_80    = CW'(80 * CLK_FREQ_MHZ - 1);
    localparam logic [CW-1:0] c_TC_50    = CW'(50 * CLK_FREQ_MHZ - 1);
    localparam logic [CW-1:0] c_TC_ZERO  = CW'(26 * CLK_FREQ_MHZ - 1);
    localparam logic [CW-1:0] c_TC_ONE   = CW'(70 * CLK_FREQ_MHZ - 1);
    localparam logic [CW-1:0] c_TC_HOLD  = CW'(c_HOLD_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HOST_LOW, S_GAP, S_RESP_LOW, S_RESP_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_END_LOW, S_HOLDOFF
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [39:0]   r_shift;
    logic [5:0]    r_bit_idx;
    logic          r_drive_low;
    logic          r_bus_meta;
    logic          r_bus_s;
    logic [7:0]    w_chk;
    logic [7:0]    w_chk_tx;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_tc_bit;

    assign w_chk     = hum_int + hum_dec + tmp_int + tmp_dec;
`ifdef DHT11_EMU_FAULT_EN
    assign w_chk_tx  = fault_chk ? ~w_chk : w_chk;
`else
    assign w_chk_tx  = w_chk;
`endif
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_tc_bit  = r_shift[39] ? c_TC_ONE : c_TC_ZERO;

    // Open-drain: only ever pull low, otherwise let the pull-up own the wire.
    assign io_dht11  = r_drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_drive_low <= 1'b0;
            r_bus_meta  <= 1'b1;
            r_bus_s     <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            r_bus_meta <= io_dht11;
            r_bus_s    <= r_bus_meta;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_bus_s) begin
                        r_cnt   <= '0;
                        r_state <= S_HOST_LOW;
                    end
                end
                S_HOST_LOW: begin
                    if (r_bus_s) begin
                        if (r_cnt == c_TC_START) begin
                            r_shift   <= {hum_int, hum_dec, tmp_int, tmp_dec, w_chk_tx};
                            r_bit_idx <= '0;
                            busy      <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_cnt != c_TC_START) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_TC_GAP) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                        r_state     <= S_RESP_LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP_LOW: begin
                    if (r_cnt == c_TC_80) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                        r_state     <= S_RESP_HIGH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_RESP_HIGH: begin
                    if (r_cnt == c_TC_80) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b1;
                        r_state     <= S_BIT_LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_BIT_LOW: begin
                    if (r_cnt == c_TC_50) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                        r_state     <= S_BIT_HIGH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_BIT_HIGH: begin
                    // High time encodes the current MSB; shift only once it has been sent.
                    if (r_cnt == w_tc_bit) begin
                        r_cnt       <= '0;
                        r_shift     <= {r_shift[38:0], 1'b0};
                        r_bit_idx   <= r_bit_idx + 6'd1;
                        r_drive_low <= 1'b1;
                        r_state     <= (r_bit_idx == 6'd39) ? S_END_LOW : S_BIT_LOW;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_END_LOW: begin
                    if (r_cnt == c_TC_50) begin
                        r_cnt       <= '0;
                        r_drive_low <= 1'b0;
                        frame_done  <= 1'b1;
                        r_state     <= S_HOLDOFF;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_HOLDOFF: begin
                    if (r_cnt == c_TC_HOLD) begin
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt       <= '0;
                    r_drive_low <= 1'b0;
                    busy        <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_emulator.sv
`default_nettype none
// Directed bench for dht11_emulator: drives host starts on a pulled-up bus and
// decodes the response waveform by sampling the bus on falling clock edges.
module tb_dht11_emulator;

    localparam int MHZ   = 1;
    localparam int START = 100;
    localparam int HOLD  = 200;
    localparam int DLY   = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_low;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic       busy, frame_done;
    wire        io_dht11;
`ifdef DHT11_EMU_FAULT_EN
    logic       fault_chk;
`endif

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    pullup (io_dht11);
    assign io_dht11 = host_low ? 1'b0 : 1'bz;

    dht11_emulator #(
        .CLK_FREQ_MHZ (MHZ),
        .START_MIN_US (START),
        .RESP_DELAY_US(DLY),
        .HOLDOFF_US   (HOLD)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .io_dht11  (io_dht11),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .tmp_int   (tmp_int),
        .tmp_dec   (tmp_dec),
`ifdef DHT11_EMU_FAULT_EN
        .fault_chk (fault_chk),
`endif
        .busy      (busy),
        .frame_done(frame_done)
    );

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Count consecutive falling-edge samples at 'level', bounded by 'limit'.
    task automatic measure(input logic level, input int limit, output int n);
        n = 0;
        while (io_dht11 === level && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic host_pulse(input int len);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    // action 1: host pulse during bit 5 low; action 2: change hum_int during bit 3.
    task automatic run_frame(input string tag, input logic [7:0] h, hd, t, td,
                             input int action, input logic [39:0] exp, output int n_one);
        int gap, lo, hi, n, bad_low, bad_high, end_lo, fd0;
        logic [39:0] data;
        hum_int = h; hum_dec = hd; tmp_int = t; tmp_dec = td;
        fd0 = fd_cnt;
        host_pulse(120);
        measure(1'b1, 200, gap);
        gap = gap + 1;
        measure(1'b0, 200, lo);
        measure(1'b1, 200, hi);
        bad_low = 0; bad_high = 0; n_one = 0; data = '0;
        for (int i = 0; i < 40; i++) begin
            if (action == 2 && i == 3) hum_int = 8'h11;
            if (action == 1 && i == 5) begin
                host_low = 1'b1;
                repeat (10) @(negedge clk);
                host_low = 1'b0;
                measure(1'b0, 200, n);
                n = n + 10;
            end else begin
                measure(1'b0, 200, n);
            end
            if (n != 50) bad_low++;
            measure(1'b1, 200, n);
            if (n == 70) n_one++;
            else if (n != 26) bad_high++;
            data = {data[38:0], (n == 70)};
        end
        measure(1'b0, 200, end_lo);
        check({tag, "_gap"}, 64'(gap >= 2 + DLY && gap <= 3 + DLY), 64'd1);
        check({tag, "_resp_lo"}, 64'(lo), 64'd80);
        check({tag, "_resp_hi"}, 64'(hi), 64'd80);
        check({tag, "_bit_lo"}, 64'(bad_low), 64'd0);
        check({tag, "_bit_hi"}, 64'(bad_high), 64'd0);
        check({tag, "_data"}, 64'(data), 64'(exp));
        check({tag, "_end_lo"}, 64'(end_lo), 64'd50);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        check({tag, "_fdone"}, 64'(fd_cnt - fd0), 64'd1);
    endtask

    initial begin
        int n, n_one, bc0;
        logic [39:0] exp_fault;
        reset = 1'b0; host_low = 1'b0;
        hum_int = '0; hum_dec = '0; tmp_int = '0; tmp_dec = '0;
`ifdef DHT11_EMU_FAULT_EN
        fault_chk = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("rst_bus", 64'(io_dht11), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fdone", 64'(frame_done), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Short host low: rejected as a glitch.
        bc0 = busy_cnt;
        host_pulse(60);
        measure(1'b1, 100, n);
        check("glitch_bus", 64'(n), 64'd100);
        check("glitch_busy", 64'(busy_cnt - bc0), 64'd0);

        // 45/00/27/00 -> 2D 00 1B 00, chk 48.
        run_frame("fA", 8'd45, 8'd0, 8'd27, 8'd0, 0, 40'h2D_00_1B_00_48, n_one);
        check("fA_ones", 64'(n_one), 64'd10);
        wait_idle("fA_idle");

        // All FF: chk wraps to FC; 38 one-bits.
        run_frame("fF", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 40'hFF_FF_FF_FF_FC, n_one);
        check("fF_ones", 64'(n_one), 64'd38);
        wait_idle("fF_idle");

        // Input change mid-frame does not affect the latched frame.
        run_frame("fL", 8'd45, 8'd0, 8'd27, 8'd0, 2, 40'h2D_00_1B_00_48, n_one);
        check("fL_hum", 64'(hum_int), 64'h11);
        wait_idle("fL_idle");

        // Host pulse during a bit low, then a full-length start during holdoff.
        run_frame("fH", 8'h12, 8'h34, 8'h56, 8'h78, 1, 40'h12_34_56_78_14, n_one);
        host_pulse(120);
        check("hold_busy", 64'(busy), 64'd1);
        wait_idle("fH_idle");
        bc0 = busy_cnt;
        measure(1'b1, 150, n);
        check("hold_norestart", 64'(n), 64'd150);
        check("hold_nobusy", 64'(busy_cnt - bc0), 64'd0);
        run_frame("fN", 8'h12, 8'h34, 8'h56, 8'h78, 0, 40'h12_34_56_78_14, n_one);
        wait_idle("fN_idle");

        // Reset while the response low is being driven.
        hum_int = 8'd45; hum_dec = 8'd0; tmp_int = 8'd27; tmp_dec = 8'd0;
        host_pulse(120);
        measure(1'b1, 200, n);
        check("mid_drive", 64'(io_dht11), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_bus", 64'(io_dht11), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        measure(1'b1, 20, n);
        check("mid_rst_quiet", 64'(n), 64'd20);
`ifdef DHT11_EMU_FAULT_EN
        fault_chk = 1'b1;
        exp_fault = 40'h2D_00_1B_00_B7;
`else
        exp_fault = 40'h2D_00_1B_00_48;
`endif
        run_frame("fR", 8'd45, 8'd0, 8'd27, 8'd0, 0, exp_fault, n_one);
        wait_idle("fR_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
